rr_grant_sched: RTL

Round-robin scheduler that shares one resource among 2^SEL_W requesters. It issues a registered grant as a binary index plus a one-hot vector; the one-hot vector is the decode of the index. The grant is held until the holder releases it. The scheduler sits in front of a shared datapath and drives its select and enable lines through the one-hot grant.

---
 rtl/rr_grant_sched.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/rr_grant_sched.sv
// -----------------------------------------------------------------------------
// rr_grant_sched -- round-robin scheduler for one shared resource.
//
// Shares a single resource among N = 2**SEL_W requesters. A winner is picked in
// IDLE by searching circularly from the priority pointer ptr. The grant is then
// held in BUSY until the holder asserts done or drops its request. After a
// release, ptr moves to the slot just past the holder, so a request that stays
// asserted is served within N grants. Every output comes from a flop, so there
// is no combinational path from an input to an output.
//
// Optional feature (compile-time macro RR_GRANT_TIMEOUT_EN):
//   When defined, an 8-bit hold counter forces a release after HOLD_MAX grant
//   cycles. timeout then pulses high for the first cycle with gnt_vld low.
//   When undefined, no counter is built and timeout is tied low.
//
// Parameters:
//   SEL_W    - index width; number of requesters N = 2**SEL_W
//   HOLD_MAX - maximum grant length in cycles with the feature on (1..255)
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   synchronous, active-high reset; overrides every other input
//   req     in   [N]      request vector, bit i = requester i
//   done    in            holder releases the grant (ignored in IDLE)
//   gnt     out  [N]      one-hot grant, 1 << gnt_idx while gnt_vld, else 0
//   gnt_idx out  [SEL_W]  index of the current or last holder
//   gnt_vld out           grant active
//   timeout out           one-cycle pulse after a forced release
// -----------------------------------------------------------------------------
module rr_grant_sched #(
    parameter int SEL_W    = 6,
    parameter int HOLD_MAX = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [(1<<SEL_W)-1:0]   req,
    input  logic                    done,
    output logic [(1<<SEL_W)-1:0]   gnt,
    output logic [SEL_W-1:0]        gnt_idx,
    output logic                    gnt_vld,
    output logic                    timeout
);

    localparam int N = 1 << SEL_W;

    // Reject an illegal hold limit at elaboration time.
    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_max_check
        $error("rr_grant_sched: HOLD_MAX must lie in 1..255");
    end

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   ptr, ptr_nxt;
    logic [SEL_W-1:0]   gnt_idx_nxt;
    logic [N-1:0]       gnt_nxt;
    logic               gnt_vld_nxt;
    logic               timeout_nxt;

    logic               win_found;
    logic [SEL_W-1:0]   win_idx;
    logic [SEL_W-1:0]   cand;

    logic               normal_rel;
    logic               force_rel;

`ifdef RR_GRANT_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
    logic [7:0]         hold_cnt, hold_cnt_nxt;
`endif

    // -------------------------------------------------------------------------
    // Circular priority search. The candidate index is ptr + k; its SEL_W-bit
    // width makes the sum wrap from N-1 back to 0 without a modulo.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable written here gets a default before any branch,
        // so no path leaves it holding an old value and no latch is inferred.
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = ptr + SEL_W'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic.
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        gnt_idx_nxt = gnt_idx;
        gnt_nxt     = gnt;
        gnt_vld_nxt = gnt_vld;
        timeout_nxt = 1'b0;
        normal_rel  = 1'b0;
        force_rel   = 1'b0;
`ifdef RR_GRANT_TIMEOUT_EN
        hold_cnt_nxt = hold_cnt;
`endif

        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt            = BUSY;
                    gnt_vld_nxt          = 1'b1;
                    gnt_idx_nxt          = win_idx;
                    gnt_nxt              = '0;
                    gnt_nxt[win_idx]     = 1'b1;
`ifdef RR_GRANT_TIMEOUT_EN
                    hold_cnt_nxt         = 8'd0;
`endif
                end
            end

            BUSY: begin
                normal_rel = done || !req[gnt_idx];
`ifdef RR_GRANT_TIMEOUT_EN
                // A voluntary release wins over the limit, so timeout only
                // pulses when the holder would otherwise have kept the grant.
                force_rel  = !normal_rel && (hold_cnt == HOLD_LAST);
`endif
                if (normal_rel || force_rel) begin
                    state_nxt   = IDLE;
                    gnt_vld_nxt = 1'b0;
                    gnt_nxt     = '0;
                    ptr_nxt     = gnt_idx + 1'b1;
                    timeout_nxt = force_rel;
                end
`ifdef RR_GRANT_TIMEOUT_EN
                else begin
                    hold_cnt_nxt = hold_cnt + 8'd1;
                end
`endif
            end

            default: begin
                state_nxt   = IDLE;
                gnt_vld_nxt = 1'b0;
                gnt_nxt     = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: flops use non-blocking assignments, so every register here
        // samples the pre-edge values and the order of these lines does not matter.
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt     <= '0;
            gnt_idx <= '0;
            gnt_vld <= 1'b0;
            timeout <= 1'b0;
`ifdef RR_GRANT_TIMEOUT_EN
            hold_cnt <= 8'd0;
`endif
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            gnt     <= gnt_nxt;
            gnt_idx <= gnt_idx_nxt;
            gnt_vld <= gnt_vld_nxt;
            timeout <= timeout_nxt;
`ifdef RR_GRANT_TIMEOUT_EN
            hold_cnt <= hold_cnt_nxt;
`endif
        end
    end

endmodule
